// File: rtl/imm_gen_pipe_if.sv
// Decode-side handshake bundle for imm_gen_pipe.
// master = upstream/downstream driver, slave = the generator.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [2:0]       in_immsrc;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  modport master (
    output in_valid, in_instr, in_immsrc, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_instr, in_immsrc, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_err
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with a 2-entry output buffer.
// Decode can stall downstream without dropping immediates.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  imm_gen_pipe_if.slave bus
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("imm_gen_pipe: TAG_W must be >= 1");
  end

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } entry_t;

  state_e          state_q, state_d;
  entry_t          head_q, head_d;
  entry_t          tail_q, tail_d;
  entry_t          new_e;
  logic [XLEN-1:0] imm_w;
  logic            err_w;
  logic            push;
  logic            pop;
  logic [31:0]     ins;
  logic            unused_opcode;

  assign ins           = bus.in_instr;
  assign unused_opcode = ^ins[6:0];

  // Format decode and extension of the incoming instruction
  always_comb begin
    imm_w = '0;
    err_w = 1'b0;
    unique case (bus.in_immsrc)
      3'b000: imm_w = XLEN'(signed'(ins[31:20]));
      3'b001: imm_w = XLEN'(signed'({ins[31:25], ins[11:7]}));
      3'b010: imm_w = XLEN'(signed'({ins[31], ins[7],
                                     ins[30:25], ins[11:8],
                                     1'b0}));
      3'b011: imm_w = XLEN'(signed'({ins[31], ins[19:12],
                                     ins[20], ins[30:21],
                                     1'b0}));
      3'b100: imm_w = XLEN'(signed'({ins[31:12], 12'b0}));
      3'b101: imm_w = XLEN'(ins[19:15]);
      3'b110: begin
        if (XLEN == 64) imm_w = XLEN'(ins[25:20]);
        else            imm_w = XLEN'(ins[24:20]);
      end
      3'b111: err_w = 1'b1;
    endcase
  end

  assign new_e = '{imm: imm_w, tag: bus.in_tag, err: err_w};

  assign bus.in_ready  = rst_n & (state_q != FULL);
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_imm   = head_q.imm;
  assign bus.out_tag   = head_q.tag;
  assign bus.out_err   = head_q.err;

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  // Occupancy and entry movement for the 2-deep FIFO
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = new_e;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = new_e;
        end else if (push) begin
          tail_d  = new_e;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State and storage registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomized bench for imm_gen_pipe at XLEN 32 and 64.
// Both instances see identical stimulus and a shared scoreboard.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) b32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) b64 ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b32.slave)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b64.slave)
  );

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [4:0]  tag;
  } txn_t;

  txn_t q[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Immediate value as an integer offset, built from field weights
  function automatic logic [63:0] ref_imm(input logic [31:0] ins,
                                          input logic [2:0] src,
                                          input int xl);
    longint v;
    v = 0;
    case (src)
      3'd0: begin
        v = longint'(ins[31:20]);
        if (ins[31]) v = v - 4096;
      end
      3'd1: begin
        v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
        if (ins[31]) v = v - 4096;
      end
      3'd2: begin
        v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
          + longint'(ins[11:8]) * 2;
        if (ins[31]) v = v - 4096;
      end
      3'd3: begin
        v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
          + longint'(ins[30:21]) * 2;
        if (ins[31]) v = v - 1048576;
      end
      3'd4: begin
        v = longint'(ins[31:12]) * 4096;
        if (ins[31]) v = v - 64'sh1_0000_0000;
      end
      3'd5: v = longint'(ins[19:15]);
      3'd6: v = (xl == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
      default: v = 0;
    endcase
    if (xl == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return 64'(v);
  endfunction

  task automatic drive(input logic iv, input logic [31:0] ins,
                       input logic [2:0] src, input logic [4:0] tg,
                       input logic ordy);
    b32.in_valid  = iv;
    b32.in_instr  = ins;
    b32.in_immsrc = src;
    b32.in_tag    = tg;
    b32.out_ready = ordy;
    b64.in_valid  = iv;
    b64.in_instr  = ins;
    b64.in_immsrc = src;
    b64.in_tag    = tg;
    b64.out_ready = ordy;
  endtask

  // One clock: check outputs mid-cycle, then advance the model
  task automatic cycle(input logic iv, input logic [31:0] ins,
                       input logic [2:0] src, input logic [4:0] tg,
                       input logic ordy);
    bit   push;
    bit   pop;
    txn_t h;
    txn_t n;
    drive(iv, ins, src, tg, ordy);
    @(negedge clk);
    check("in_ready32", 64'(b32.in_ready), 64'(q.size() < 2));
    check("in_ready64", 64'(b64.in_ready), 64'(q.size() < 2));
    check("out_valid32", 64'(b32.out_valid), 64'(q.size() > 0));
    check("out_valid64", 64'(b64.out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      h = q[0];
      check("imm32", 64'(b32.out_imm), ref_imm(h.instr, h.src, 32));
      check("imm64", b64.out_imm, ref_imm(h.instr, h.src, 64));
      check("tag32", 64'(b32.out_tag), 64'(h.tag));
      check("tag64", 64'(b64.out_tag), 64'(h.tag));
      check("err32", 64'(b32.out_err), 64'(h.src == 3'd7));
      check("err64", 64'(b64.out_err), 64'(h.src == 3'd7));
    end
    pop  = ordy && (q.size() > 0);
    push = iv && (q.size() < 2);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) begin
      n.instr = ins;
      n.src   = src;
      n.tag   = tg;
      q.push_back(n);
    end
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, $urandom, 3'($urandom_range(0, 6)), 5'($urandom), 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_in_ready32", 64'(b32.in_ready), 64'd0);
    check("rst_in_ready64", 64'(b64.in_ready), 64'd0);
    @(posedge clk);
    #1;
    q.delete();
    check("rst_out_valid32", 64'(b32.out_valid), 64'd0);
    check("rst_out_valid64", 64'(b64.out_valid), 64'd0);
    check("rst_imm32", 64'(b32.out_imm), 64'd0);
    check("rst_imm64", b64.out_imm, 64'd0);
    check("rst_tag", 64'(b64.out_tag), 64'd0);
    check("rst_err", 64'(b64.out_err), 64'd0);
    rst_n = 1'b1;
    drive(1'b0, 32'd0, 3'd0, 5'd0, 1'b0);
    #1;
    check("post_rst_in_ready32", 64'(b32.in_ready), 64'd1);
    check("post_rst_in_ready64", 64'(b64.in_ready), 64'd1);
  endtask

  initial begin
    drive(1'b0, 32'd0, 3'd0, 5'd0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    cycle(1'b1, 32'hFFF0_0093, 3'd0, 5'd1, 1'b1);
    check("t1_imm32", 64'(b32.out_imm), 64'h0000_0000_FFFF_FFFF);
    check("t1_tag", 64'(b32.out_tag), 64'd1);
    check("t1_valid", 64'(b32.out_valid), 64'd1);

    cycle(1'b1, 32'hFE00_0EE3, 3'd2, 5'd2, 1'b1);
    check("t2_b_imm32", 64'(b32.out_imm), 64'h0000_0000_FFFF_FFFC);
    cycle(1'b1, 32'h000F_D073, 3'd5, 5'd3, 1'b1);
    check("t2_z_imm32", 64'(b32.out_imm), 64'h0000_0000_0000_001F);

    cycle(1'b1, 32'h8000_00B7, 3'd4, 5'd4, 1'b1);
    check("t3_u_imm64", b64.out_imm, 64'hFFFF_FFFF_8000_0000);
    check("t3_u_imm32", 64'(b32.out_imm), 64'h0000_0000_8000_0000);
    cycle(1'b1, 32'h03F0_1013, 3'd6, 5'd5, 1'b1);
    check("t3_sh_imm64", b64.out_imm, 64'h0000_0000_0000_003F);
    check("t3_sh_imm32", 64'(b32.out_imm), 64'h0000_0000_0000_001F);
    cycle(1'b0, 32'd0, 3'd0, 5'd0, 1'b1);

    cycle(1'b1, $urandom, 3'd0, 5'd1, 1'b0);
    cycle(1'b1, $urandom, 3'd1, 5'd2, 1'b0);
    check("t4_full_ready", 64'(b32.in_ready), 64'd0);
    check("t4_head_tag", 64'(b32.out_tag), 64'd1);
    cycle(1'b1, 32'h1234_5678, 3'd3, 5'd3, 1'b0);
    check("t4_hold_tag", 64'(b32.out_tag), 64'd1);
    repeat (2) cycle(1'b1, 32'h1234_5678, 3'd3, 5'd3, 1'b1);
    repeat (2) cycle(1'b0, 32'd0, 3'd0, 5'd0, 1'b1);

    for (int i = 0; i < 8; i++)
      cycle(1'b1, $urandom, 3'($urandom_range(0, 6)), 5'(i), 1'b1);
    cycle(1'b1, $urandom, 3'd7, 5'd9, 1'b1);
    check("t5_err", 64'(b32.out_err), 64'd1);
    check("t5_err_imm", b64.out_imm, 64'd0);
    cycle(1'b0, 32'd0, 3'd0, 5'd0, 1'b1);

    cycle(1'b1, $urandom, 3'd0, 5'd7, 1'b0);
    cycle(1'b1, $urandom, 3'd1, 5'd8, 1'b0);
    do_reset();
    cycle(1'b1, 32'h8000_00B7, 3'd4, 5'd6, 1'b1);
    check("t6_valid", 64'(b64.out_valid), 64'd1);
    check("t6_imm64", b64.out_imm, 64'hFFFF_FFFF_8000_0000);
    cycle(1'b0, 32'd0, 3'd0, 5'd0, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 3) != 0, $urandom,
              3'($urandom), 5'($urandom),
              $urandom_range(0, 3) != 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
